// File: rtl/half_adder.sv
// Bit-parallel half adder: per-lane sum = a^b, cout = a&b, with a valid qualifier.
// REGISTERED selects a 1-cycle registered path or a purely combinational one.
module half_adder #(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b1,
  parameter bit          RESET_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] cout_c;

  // Lanes are independent: no carry chain between bits.
  always_comb begin
    sum_c  = a ^ b;
    cout_c = a & b;
  end

  generate
    if (REGISTERED) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum       <= {WIDTH{RESET_VAL}};
          cout      <= {WIDTH{RESET_VAL}};
          out_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            sum  <= sum_c;
            cout <= cout_c;
          end
        end
      end
    end else begin : g_comb
      // Reset only masks the qualifier; data stays a live function of a/b.
      always_comb begin
        sum       = sum_c;
        cout      = cout_c;
        out_valid = in_valid & ~rst;
      end
    end
  endgenerate

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: registered WIDTH=1 and WIDTH=8, combinational WIDTH=1.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic       s1, c1, ov1;
  logic       v8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8, c8;
  logic       ov8;
  logic       v0 = 1'b0, a0 = 1'b0, b0 = 1'b0;
  logic       s0, c0, ov0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .REGISTERED(1'b1), .RESET_VAL(1'b0)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
    .sum(s1), .cout(c1), .out_valid(ov1)
  );

  half_adder #(.WIDTH(8), .REGISTERED(1'b1), .RESET_VAL(1'b0)) u_r8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
    .sum(s8), .cout(c8), .out_valid(ov8)
  );

  half_adder #(.WIDTH(1), .REGISTERED(1'b0), .RESET_VAL(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(v0), .a(a0), .b(b0),
    .sum(s0), .cout(c0), .out_valid(ov0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sample one time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ov1) assert ((s1 & c1) == 1'b0) else $error("sum&cout overlap on 1-bit lane");
    if (ov8) assert ((s8 & c8) == 8'h00) else $error("sum&cout overlap on 8-bit lanes");
  end

  // Directed vectors: {a, b, expected sum, expected cout}
  logic [3:0] vec [4] = '{4'b0000, 4'b0110, 4'b1010, 4'b1101};

  initial begin
    // Reset held across an edge with in_valid high: must be ignored.
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    v0 = 1'b1;
    tick();
    check("rst_sum", s1, 1'b0);
    check("rst_cout", c1, 1'b0);
    check("rst_ov", ov1, 1'b0);
    check("rst_ov8", ov8, 1'b0);
    check("rst_comb_ov", ov0, 1'b0);

    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; v0 = 1'b0;

    // Exhaustive WIDTH=1, one new pair per cycle.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] t;
      @(negedge clk);
      t = vec[i];
      a1 = t[3]; b1 = t[2]; v1 = 1'b1;
      tick();
      check($sformatf("tt%0d_sum", i), s1, t[1]);
      check($sformatf("tt%0d_cout", i), c1, t[0]);
      check($sformatf("tt%0d_ov", i), ov1, 1'b1);
    end

    // Hold when in_valid drops.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    tick();
    check("hold_load_cout", c1, 1'b1);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b0;
    tick();
    check("hold_sum", s1, 1'b0);
    check("hold_cout", c1, 1'b1);
    check("hold_ov", ov1, 1'b0);

    // WIDTH=8 lane independence.
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'hCC; v8 = 1'b1;
    tick();
    check("w8_sum", s8, 8'h3C);
    check("w8_cout", c8, 8'hC0);
    check("w8_ov", ov8, 1'b1);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01;
    tick();
    check("w8_nocarry_sum", s8, 8'hFE);
    check("w8_nocarry_cout", c8, 8'h01);
    @(negedge clk);
    v8 = 1'b0;

    // Asynchronous reset mid-stream.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    tick();
    check("mid_load_cout", c1, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_sum", s1, 1'b0);
    check("async_cout", c1, 1'b0);
    check("async_ov", ov1, 1'b0);
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0;
    tick();
    check("post_rst_cout", c1, 1'b0);
    check("post_rst_ov", ov1, 1'b0);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    tick();
    check("post_rst_first_sum", s1, 1'b1);
    check("post_rst_first_cout", c1, 1'b0);
    check("post_rst_first_ov", ov1, 1'b1);
    @(negedge clk);
    v1 = 1'b0;

    // Combinational variant: no clock needed.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] t;
      t = vec[i];
      a0 = t[3]; b0 = t[2]; v0 = i[0];
      #1;
      check($sformatf("comb%0d_sum", i), s0, t[1]);
      check($sformatf("comb%0d_cout", i), c0, t[0]);
      check($sformatf("comb%0d_ov", i), ov0, i[0]);
    end
    v0 = 1'b1; rst = 1'b1;
    #1;
    check("comb_rst_ov", ov0, 1'b0);
    check("comb_rst_sum", s0, 1'b0);
    rst = 1'b0;
    #1;
    check("comb_release_ov", ov0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
